smart_parking_ctrl: RTL and testbench

Clocked, parametrised parking-lot controller and successor to the combinational `smart_parking` block. It owns the spot-occupancy map and per-spot entry timestamps, and runs a free-running time base. It services entry and exit request pulses with a registered one-cycle response. It sits between the gate sensors/ticket logic and the billing/display logic, and reports parked/empty counts and the parked duration of each departing car.

---
 rtl/smart_parking_pkg.sv | 19 +
 rtl/smart_parking_ctrl_if.sv | 39 +++
 rtl/smart_parking_ctrl_spot_alloc.sv | 26 ++
 rtl/smart_parking_ctrl.sv | 110 +++++++++++
 tb/tb_smart_parking_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/smart_parking_pkg.sv
// Shared constants, response FSM state type and width helper for the
// smart_parking_ctrl block.
package smart_parking_pkg;

    localparam int DEF_N_SPOTS  = 8;
    localparam int DEF_TIME_W   = 8;
    localparam int DEF_TICK_DIV = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } resp_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/smart_parking_ctrl_if.sv
// Request/response and status bundle between the gate logic (master) and
// the parking controller (slave).
interface smart_parking_ctrl_if
    import smart_parking_pkg::*;
#(
    parameter int N_SPOTS = DEF_N_SPOTS,
    parameter int TIME_W  = DEF_TIME_W
);
    localparam int IDX_W = $clog2(N_SPOTS);
    localparam int CNT_W = $clog2(N_SPOTS + 1);

    logic               open_i;
    logic               entry_req;
    logic               exit_req;
    logic [IDX_W-1:0]   exit_spot;
    logic               entry_ack;
    logic               entry_rej;
    logic [IDX_W-1:0]   entry_spot;
    logic               exit_ack;
    logic               exit_err;
    logic [TIME_W-1:0]  time_total;
    logic [N_SPOTS-1:0] occupancy;
    logic [CNT_W-1:0]   parked;
    logic [CNT_W-1:0]   empty;
    logic [TIME_W-1:0]  now;

    modport master (
        output open_i, entry_req, exit_req, exit_spot,
        input  entry_ack, entry_rej, entry_spot, exit_ack, exit_err,
               time_total, occupancy, parked, empty, now
    );

    modport slave (
        input  open_i, entry_req, exit_req, exit_spot,
        output entry_ack, entry_rej, entry_spot, exit_ack, exit_err,
               time_total, occupancy, parked, empty, now
    );

endinterface

// File: rtl/smart_parking_ctrl_spot_alloc.sv
// Lowest-index free spot finder: priority encoder on the zero bits of the
// occupancy map.
module spot_alloc
    import smart_parking_pkg::*;
#(
    parameter int N_SPOTS = DEF_N_SPOTS,
    parameter int IDX_W   = $clog2(DEF_N_SPOTS)
) (
    input  logic [N_SPOTS-1:0] occupancy,
    output logic [IDX_W-1:0]   free_idx,
    output logic               any_free
);

    // Scanning from the top down lets the lowest free index win last.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/smart_parking_ctrl.sv
// Clocked parking-lot controller: occupancy map, per-spot entry timestamps,
// free-running time base and one-cycle registered entry/exit responses.
module smart_parking_ctrl
    import smart_parking_pkg::*;
#(
    parameter int N_SPOTS  = DEF_N_SPOTS,
    parameter int TIME_W   = DEF_TIME_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input logic               clk,
    input logic               rst,
    smart_parking_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_SPOTS);
    localparam int CNT_W = $clog2(N_SPOTS + 1);
    localparam int PRE_W = clog2_min1(TICK_DIV);
    localparam logic [IDX_W:0]   SPOT_LIMIT = (IDX_W + 1)'(N_SPOTS);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);

    resp_state_t        state;
    logic [PRE_W-1:0]   prescaler;
    logic [TIME_W-1:0]  ts [N_SPOTS];

    logic [IDX_W-1:0]   free_idx;
    logic               any_free;
    logic               entry_ok;
    logic               exit_ok;
    logic               exit_in_range;
    logic [N_SPOTS-1:0] entry_mask;
    logic [N_SPOTS-1:0] exit_mask;
    logic [N_SPOTS-1:0] occ_next;
    logic [CNT_W-1:0]   parked_next;

    spot_alloc #(
        .N_SPOTS (N_SPOTS),
        .IDX_W   (IDX_W)
    ) u_spot_alloc (
        .occupancy (bus.occupancy),
        .free_idx  (free_idx),
        .any_free  (any_free)
    );

    // Allocation sees the map before any same-cycle exit, so a spot being
    // vacated now can never be handed out in this same cycle.
    always_comb begin
        exit_in_range = ({1'b0, bus.exit_spot} < SPOT_LIMIT);
        entry_ok      = bus.entry_req & bus.open_i & any_free;
        exit_ok       = bus.exit_req & exit_in_range & bus.occupancy[bus.exit_spot];
        entry_mask    = entry_ok ? (N_SPOTS'(1) << free_idx) : '0;
        exit_mask     = exit_ok ? (N_SPOTS'(1) << bus.exit_spot) : '0;
        occ_next      = (bus.occupancy & ~exit_mask) | entry_mask;
        parked_next   = bus.parked + CNT_W'(entry_ok) - CNT_W'(exit_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            prescaler      <= '0;
            bus.now        <= '0;
            bus.entry_ack  <= 1'b0;
            bus.entry_rej  <= 1'b0;
            bus.exit_ack   <= 1'b0;
            bus.exit_err   <= 1'b0;
            bus.entry_spot <= '0;
            bus.time_total <= '0;
            bus.occupancy  <= '0;
            bus.parked     <= '0;
            bus.empty      <= CNT_W'(N_SPOTS);
            for (int i = 0; i < N_SPOTS; i++) begin
                ts[i] <= '0;
            end
        end else begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                bus.now   <= bus.now + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // A request in RESP is serviced just like one in IDLE.
            if (bus.entry_req || bus.exit_req) begin
                state         <= RESP;
                bus.entry_ack <= entry_ok;
                bus.entry_rej <= bus.entry_req & ~entry_ok;
                bus.exit_ack  <= exit_ok;
                bus.exit_err  <= bus.exit_req & ~exit_ok;
            end else if (state == RESP) begin
                state         <= IDLE;
                bus.entry_ack <= 1'b0;
                bus.entry_rej <= 1'b0;
                bus.exit_ack  <= 1'b0;
                bus.exit_err  <= 1'b0;
            end

            if (entry_ok) begin
                bus.entry_spot <= free_idx;
                ts[free_idx]   <= bus.now;
            end
            if (exit_ok) begin
                bus.time_total <= bus.now - ts[bus.exit_spot];
            end

            bus.occupancy <= occ_next;
            bus.parked    <= parked_next;
            bus.empty     <= CNT_W'(N_SPOTS) - parked_next;
        end
    end

endmodule

// File: tb/tb_smart_parking_ctrl.sv
// Directed, table-driven bench for smart_parking_ctrl at default parameters,
// with hand-written sequences for durations, wrap-around and mid-run reset.
module tb_smart_parking_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   edge_cnt;
    logic [7:0] model_now;

    typedef struct {
        logic       open_i;
        logic       entry;
        logic       exit_r;
        logic [2:0] spot;
        logic       e_ack;
        logic       e_rej;
        logic [2:0] e_spot;
        logic       x_ack;
        logic       x_err;
        logic [7:0] occ;
        logic [3:0] parked;
        logic [7:0] ttot;
    } vec_t;

    vec_t vecs [17];

    smart_parking_ctrl_if #(.N_SPOTS(8), .TIME_W(8)) bus ();

    smart_parking_ctrl #(
        .N_SPOTS  (8),
        .TIME_W   (8),
        .TICK_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference time base: one time unit every four edges out of reset.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end
    assign model_now = 8'(edge_cnt / 4);

    function automatic vec_t mk(logic op, logic en, logic ex, logic [2:0] sp,
                                logic ea, logic er, logic [2:0] es,
                                logic xa, logic xe, logic [7:0] oc,
                                logic [3:0] pk, logic [7:0] tt);
        vec_t v;
        v.open_i = op; v.entry = en; v.exit_r = ex; v.spot = sp;
        v.e_ack = ea; v.e_rej = er; v.e_spot = es; v.x_ack = xa; v.x_err = xe;
        v.occ = oc; v.parked = pk; v.ttot = tt;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic op, input logic en,
                                  input logic ex, input logic [2:0] sp);
        bus.open_i    = op;
        bus.entry_req = en;
        bus.exit_req  = ex;
        bus.exit_spot = sp;
        tick();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
    endtask

    task automatic run_to(input logic [7:0] target);
        int n;
        n = 0;
        while (model_now != target && n < 3000) begin
            tick();
            n++;
        end
        check_output("run_to_bound", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.open_i = 1'b0; bus.entry_req = 1'b0; bus.exit_req = 1'b0;
        bus.exit_spot = '0;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1, 1, 0, 0, 1, 0, 3'(i), 0, 0,
                         8'((9'd1 << (i + 1)) - 9'd1), 4'(i + 1), 8'd0);
        end
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 3'd7, 0, 0, 8'hFF, 4'd8, 8'd0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 1, 3'd7, 0, 0, 8'hFF, 4'd8, 8'd0);
        vecs[10] = mk(1, 1, 1, 2, 0, 1, 3'd7, 1, 0, 8'hFB, 4'd7, 8'd2);
        vecs[11] = mk(1, 1, 0, 0, 1, 0, 3'd2, 0, 0, 8'hFF, 4'd8, 8'd2);
        vecs[12] = mk(1, 0, 1, 3, 0, 0, 3'd2, 1, 0, 8'hF7, 4'd7, 8'd3);
        vecs[13] = mk(1, 0, 1, 3, 0, 0, 3'd2, 0, 1, 8'hF7, 4'd7, 8'd3);
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 3'd2, 0, 0, 8'hF7, 4'd7, 8'd3);
        vecs[15] = mk(0, 1, 1, 5, 0, 1, 3'd2, 1, 0, 8'hD7, 4'd6, 8'd2);
        vecs[16] = mk(1, 1, 0, 0, 1, 0, 3'd3, 0, 0, 8'hDF, 4'd7, 8'd2);

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_occupancy",  32'(bus.occupancy),  32'h00);
        check_output("rst_parked",     32'(bus.parked),     32'd0);
        check_output("rst_empty",      32'(bus.empty),      32'd8);
        check_output("rst_now",        32'(bus.now),        32'd0);
        check_output("rst_time_total", 32'(bus.time_total), 32'd0);
        check_output("rst_entry_spot", 32'(bus.entry_spot), 32'd0);
        check_output("rst_pulses",
                     32'({bus.entry_ack, bus.entry_rej, bus.exit_ack, bus.exit_err}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].open_i, vecs[i].entry, vecs[i].exit_r, vecs[i].spot);
            check_output($sformatf("v%0d_entry_ack", i), 32'(bus.entry_ack), 32'(vecs[i].e_ack));
            check_output($sformatf("v%0d_entry_rej", i), 32'(bus.entry_rej), 32'(vecs[i].e_rej));
            check_output($sformatf("v%0d_entry_spot", i), 32'(bus.entry_spot), 32'(vecs[i].e_spot));
            check_output($sformatf("v%0d_exit_ack", i), 32'(bus.exit_ack), 32'(vecs[i].x_ack));
            check_output($sformatf("v%0d_exit_err", i), 32'(bus.exit_err), 32'(vecs[i].x_err));
            check_output($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(vecs[i].occ));
            check_output($sformatf("v%0d_parked", i), 32'(bus.parked), 32'(vecs[i].parked));
            check_output($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(4'd8 - vecs[i].parked));
            check_output($sformatf("v%0d_time_total", i), 32'(bus.time_total), 32'(vecs[i].ttot));
            check_output($sformatf("v%0d_now", i), 32'(bus.now), 32'(model_now));
        end

        // Pulse drops after one cycle with no new request.
        tick();
        check_output("idle_entry_ack", 32'(bus.entry_ack), 32'd0);

        // Reset in the pulse cycle of an accepted entry.
        apply_stimulus(1, 1, 0, 0);
        check_output("pre_rst_ack",  32'(bus.entry_ack),  32'd1);
        check_output("pre_rst_spot", 32'(bus.entry_spot), 32'd5);
        rst = 1'b1;
        #1;
        check_output("mid_rst_ack",       32'(bus.entry_ack), 32'd0);
        check_output("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
        check_output("mid_rst_empty",     32'(bus.empty),     32'd8);
        check_output("mid_rst_now",       32'(bus.now),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain duration: in at 5, out at 17.
        run_to(8'd5);
        apply_stimulus(1, 1, 0, 0);
        check_output("dur_entry_ack",  32'(bus.entry_ack),  32'd1);
        check_output("dur_entry_spot", 32'(bus.entry_spot), 32'd0);
        run_to(8'd17);
        apply_stimulus(1, 0, 1, 0);
        check_output("dur_exit_ack",   32'(bus.exit_ack),   32'd1);
        check_output("dur_time_total", 32'(bus.time_total), 32'd12);

        // Exit of a free spot leaves duration, map and counts alone.
        apply_stimulus(1, 0, 1, 3);
        check_output("free_exit_err",   32'(bus.exit_err),   32'd1);
        check_output("free_time_total", 32'(bus.time_total), 32'd12);
        check_output("free_occupancy",  32'(bus.occupancy),  32'd0);
        check_output("free_parked",     32'(bus.parked),     32'd0);

        // Wrapped duration: in at 250, out at 4.
        run_to(8'd250);
        apply_stimulus(1, 1, 0, 0);
        check_output("wrap_entry_ack", 32'(bus.entry_ack), 32'd1);
        run_to(8'd4);
        apply_stimulus(1, 0, 1, 0);
        check_output("wrap_exit_ack",   32'(bus.exit_ack),   32'd1);
        check_output("wrap_time_total", 32'(bus.time_total), 32'd10);
        check_output("wrap_parked",     32'(bus.parked),     32'd0);
        check_output("wrap_empty",      32'(bus.empty),      32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
